// File: rtl/y86_decode_writeback.sv
// rtl/y86_decode_writeback.sv - Y86 decode stage: register file, operand decode, E-register, write-back
// Optional feature macro: Y86_DECODE_WB_FORWARD_EN (same-cycle write-through into decoded operands).
module y86_decode_writeback #(
  parameter int          DATA_W = 64,
  parameter int          NREG   = 15,
  parameter logic [3:0]  RSP_ID = 4'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [DATA_W-1:0] in_valC,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic [DATA_W-1:0] out_valC,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM,
  input  logic              wb_valid,
  input  logic [3:0]        wb_icode,
  input  logic              wb_cnd,
  input  logic [3:0]        wb_dstE,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [3:0]        wb_dstM,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              halted,
  output logic              stat_ins
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [DATA_W-1:0] rf [NREG];

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rd_a, rd_b, val_a, val_b;
  logic              we_e, we_m;
  logic              xfer;
  logic              is_invalid;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (in_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = in_rA;
      I_RET, I_POPQ:                      src_a = RSP_ID;
      default: ;
    endcase
    case (in_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = in_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP_ID;
      default: ;
    endcase
    case (in_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = in_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP_ID;
      default: ;
    endcase
    case (in_icode)
      I_MRMOVQ, I_POPQ:                   dst_m = in_rA;
      default: ;
    endcase
  end

  // ID 0xF is "no register" and always reads as zero.
  assign rd_a = (src_a == RNONE) ? '0 : rf[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : rf[src_b];

  // A not-taken cmovXX retires with its dstE still set; suppress the E write.
  assign we_e = wb_valid && (wb_dstE != RNONE) && !((wb_icode == I_RRMOVQ) && !wb_cnd);
  assign we_m = wb_valid && (wb_dstM != RNONE);

`ifdef Y86_DECODE_WB_FORWARD_EN
  always_comb begin
    val_a = rd_a;
    if (we_m && (wb_dstM == src_a))      val_a = wb_valM;
    else if (we_e && (wb_dstE == src_a)) val_a = wb_valE;
    val_b = rd_b;
    if (we_m && (wb_dstM == src_b))      val_b = wb_valM;
    else if (we_e && (wb_dstE == src_b)) val_b = wb_valE;
  end
`else
  assign val_a = rd_a;
  assign val_b = rd_b;
`endif

  assign in_ready   = !halted && (!out_valid || out_ready);
  assign xfer       = in_valid && in_ready;
  assign is_invalid = in_icode > I_POPQ;

  // M write is issued last so it wins when both target the same register (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (we_e) rf[wb_dstE] <= wb_valE;
      if (we_m) rf[wb_dstM] <= wb_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_ifun  <= '0;
      out_valA  <= '0;
      out_valB  <= '0;
      out_valC  <= '0;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
      halted    <= 1'b0;
      stat_ins  <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_icode <= in_icode;
        out_ifun  <= in_ifun;
        out_valA  <= val_a;
        out_valB  <= val_b;
        out_valC  <= in_valC;
        out_dstE  <= dst_e;
        out_dstM  <= dst_m;
        if ((in_icode == I_HALT) || is_invalid) halted <= 1'b1;
        if (is_invalid) stat_ins <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_y86_decode_writeback.sv
// tb/tb_y86_decode_writeback.sv - randomized self-checking bench for y86_decode_writeback
// Honours Y86_DECODE_WB_FORWARD_EN to select the expected forwarding behaviour.
module tb_y86_decode_writeback;

  localparam logic [3:0] NONE = 4'hF;
  localparam logic [3:0] RSP  = 4'd4;
`ifdef Y86_DECODE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC;
  logic [3:0]  out_icode, out_ifun, out_dstE, out_dstM;
  logic [63:0] out_valA, out_valB, out_valC;
  logic        wb_valid, wb_cnd;
  logic [3:0]  wb_icode, wb_dstE, wb_dstM;
  logic [63:0] wb_valE, wb_valM;
  logic        halted, stat_ins;

  int errors = 0;
  int checks = 0;

  y86_decode_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_ifun(out_ifun),
    .out_valA(out_valA), .out_valB(out_valB), .out_valC(out_valC),
    .out_dstE(out_dstE), .out_dstM(out_dstM),
    .wb_valid(wb_valid), .wb_icode(wb_icode), .wb_cnd(wb_cnd),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .halted(halted), .stat_ins(stat_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_rf [16];
  logic        m_valid, m_halted, m_ins;
  logic [3:0]  m_icode, m_ifun, m_dste, m_dstm;
  logic [63:0] m_vala, m_valb, m_valc;

  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return RSP;
    return NONE;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
    return NONE;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
    return NONE;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return NONE;
  endfunction

  function automatic logic m_in_ready();
    return !m_halted && (!m_valid || out_ready);
  endfunction

  function automatic logic [208:0] dut_vec();
    return {out_valid, out_icode, out_ifun, out_dstE, out_dstM, out_valA, out_valB, out_valC};
  endfunction

  function automatic logic [208:0] mdl_vec();
    return {m_valid, m_icode, m_ifun, m_dste, m_dstm, m_vala, m_valb, m_valc};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_valid = 0; m_halted = 0; m_ins = 0;
    m_icode = 0; m_ifun = 0; m_dste = NONE; m_dstm = NONE;
    m_vala = 0; m_valb = 0; m_valc = 0;
  endtask

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic xfer;
    logic [3:0] sa, sb;
    logic [63:0] va, vb;
    xfer = in_valid && m_in_ready();
    sa = m_src_a(in_icode, in_rA);
    sb = m_src_b(in_icode, in_rB);
    va = m_rf[sa];
    vb = m_rf[sb];
    if (wb_valid) begin
      if (wb_dstE != NONE && !(wb_icode == 4'h2 && !wb_cnd)) m_rf[wb_dstE] = wb_valE;
      if (wb_dstM != NONE) m_rf[wb_dstM] = wb_valM;
    end
    if (FWD) begin
      va = m_rf[sa];
      vb = m_rf[sb];
    end
    if (xfer) begin
      m_valid = 1;
      m_icode = in_icode; m_ifun = in_ifun; m_valc = in_valC;
      m_vala = va; m_valb = vb;
      m_dste = m_dst_e(in_icode, in_rB);
      m_dstm = m_dst_m(in_icode, in_rA);
      if (in_icode == 4'h0 || in_icode > 4'hB) m_halted = 1;
      if (in_icode > 4'hB) m_ins = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wb_valid = 0; out_ready = 1;
  endtask

  task automatic set_in(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    in_valid = 1; in_icode = ic; in_ifun = 4'($urandom_range(0, 15));
    in_rA = ra; in_rB = rb; in_valC = vc;
  endtask

  task automatic set_wb(input logic [3:0] ic, input logic cnd, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
    wb_valid = 1; wb_icode = ic; wb_cnd = cnd;
    wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
  endtask

  // Decodes OPq rA=a rB=b so the register contents appear on out_valA/out_valB.
  task automatic read_regs(input logic [3:0] a, input logic [3:0] b);
    idle();
    set_in(4'h6, a, b, 64'h0);
    cycle();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #7;
    model_reset();
    rst_n = 1;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), mdl_vec()); end
    checks++; if (out_dstE !== NONE || out_dstM !== NONE) begin errors++; $display("FAIL reset_dst got=%h/%h exp=f/f", out_dstE, out_dstM); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (halted !== 1'b0 || stat_ins !== 1'b0) begin errors++; $display("FAIL reset_status got=%b%b exp=00", halted, stat_ins); end
  endtask

  task automatic test_irmovq();
    idle();
    set_in(4'h3, NONE, 4'd2, 64'h10);
    cycle();
    idle();
    checks++; if (out_valid !== 1'b1 || out_dstE !== 4'd2 || out_valC !== 64'h10 || out_valA !== 64'h0 || out_valB !== 64'h0)
      begin errors++; $display("FAIL irmovq got v=%b dstE=%h valC=%h valA=%h valB=%h exp v=1 dstE=2 valC=10 valA=0 valB=0",
                               out_valid, out_dstE, out_valC, out_valA, out_valB); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL irmovq_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_rrmovq();
    idle();
    set_wb(4'h6, 1'b1, 4'd3, 64'h55, NONE, 64'h0);
    cycle();
    idle();
    set_in(4'h2, 4'd3, 4'd5, 64'h0);
    cycle();
    idle();
    checks++; if (out_valA !== 64'h55 || out_dstE !== 4'd5) begin errors++; $display("FAIL rrmovq got valA=%h dstE=%h exp valA=55 dstE=5", out_valA, out_dstE); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL rrmovq_model got=%h exp=%h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_cmov();
    idle();
    set_wb(4'h2, 1'b0, 4'd5, 64'h99, NONE, 64'h0);
    cycle();
    read_regs(4'd5, NONE);
    checks++; if (out_valA !== 64'h0) begin errors++; $display("FAIL cmov_not_taken got=%h exp=0", out_valA); end
    set_wb(4'h2, 1'b1, 4'd5, 64'h99, NONE, 64'h0);
    cycle();
    read_regs(4'd5, NONE);
    checks++; if (out_valA !== 64'h99) begin errors++; $display("FAIL cmov_taken got=%h exp=99", out_valA); end
  endtask

  task automatic test_popq_rsp();
    idle();
    set_wb(4'hB, 1'b1, 4'd4, 64'h108, 4'd4, 64'h200);
    cycle();
    read_regs(4'd4, 4'd3);
    checks++; if (out_valA !== 64'h200) begin errors++; $display("FAIL popq_rsp got=%h exp=200", out_valA); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL popq_model got=%h exp=%h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_backpressure();
    logic [208:0] snap;
    idle();
    cycle();
    out_ready = 0;
    set_in(4'h3, NONE, 4'd7, 64'hABCD);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
    cycle();
    snap = mdl_vec();
    for (int i = 0; i < 3; i++) begin
      set_in(4'h6, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)), {$urandom, $urandom});
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", i, in_ready); end
      cycle();
      checks++; if (dut_vec() !== snap) begin errors++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, dut_vec(), snap); end
    end
    out_ready = 1;
    set_in(4'hA, 4'd3, NONE, 64'h0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    cycle();
    idle();
    checks++; if (out_icode !== 4'hA || out_dstE !== RSP || dut_vec() !== mdl_vec())
      begin errors++; $display("FAIL bp_release got=%h exp=%h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_icode  = 4'($urandom_range(1, 11));
      in_ifun   = 4'($urandom_range(0, 15));
      in_rA     = 4'($urandom_range(0, 15));
      in_rB     = 4'($urandom_range(0, 15));
      in_valC   = {$urandom, $urandom};
      wb_valid  = ($urandom_range(0, 1) != 0);
      wb_icode  = 4'($urandom_range(1, 11));
      wb_cnd    = ($urandom_range(0, 1) != 0);
      wb_dstE   = 4'($urandom_range(0, 15));
      wb_dstM   = 4'($urandom_range(0, 15));
      wb_valE   = {$urandom, $urandom};
      wb_valM   = {$urandom, $urandom};
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", n, in_ready, m_in_ready()); end
      cycle();
      checks++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL rand_out[%0d] got=%h exp=%h", n, dut_vec(), mdl_vec()); end
    end
    idle();
    cycle();
  endtask

  task automatic test_forward();
    logic [63:0] exp_a;
    idle();
    set_wb(4'h3, 1'b1, 4'd6, 64'h11, NONE, 64'h0);
    cycle();
    idle();
    set_wb(4'h3, 1'b1, 4'd6, 64'h77, NONE, 64'h0);
    set_in(4'h6, 4'd6, NONE, 64'h0);
    cycle();
    idle();
    exp_a = FWD ? 64'h77 : 64'h11;
    checks++; if (out_valA !== exp_a) begin errors++; $display("FAIL forward got=%h exp=%h", out_valA, exp_a); end
    read_regs(4'd6, NONE);
    checks++; if (out_valA !== 64'h77) begin errors++; $display("FAIL forward_commit got=%h exp=77", out_valA); end
  endtask

  task automatic test_reset_mid();
    idle();
    out_ready = 0;
    set_in(4'h6, 4'd6, 4'd4, 64'h1234);
    cycle();
    idle();
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_dstE !== NONE || out_valC !== 64'h0)
      begin errors++; $display("FAIL async_reset got v=%b dstE=%h valC=%h exp v=0 dstE=f valC=0", out_valid, out_dstE, out_valC); end
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1;
    out_ready = 1;
    cycle();
    read_regs(4'd6, 4'd4);
    checks++; if (out_valA !== 64'h0 || out_valB !== 64'h0) begin errors++; $display("FAIL reset_rf got=%h/%h exp=0/0", out_valA, out_valB); end
  endtask

  task automatic test_halt();
    idle();
    cycle();
    set_in(4'h0, NONE, NONE, 64'h0);
    cycle();
    idle();
    checks++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_icode !== 4'h0 || stat_ins !== 1'b0)
      begin errors++; $display("FAIL halt got h=%b v=%b icode=%h ins=%b exp h=1 v=1 icode=0 ins=0", halted, out_valid, out_icode, stat_ins); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got=%b exp=0", in_ready); end
    set_in(4'h3, NONE, 4'd1, 64'h5);
    cycle();
    cycle();
    idle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut_vec() !== mdl_vec())
      begin errors++; $display("FAIL halt_block got v=%b r=%b vec=%h exp v=0 r=0 vec=%h", out_valid, in_ready, dut_vec(), mdl_vec()); end
  endtask

  task automatic test_invalid();
    do_reset();
    set_in(4'hC, 4'd1, 4'd2, 64'h3);
    cycle();
    idle();
    checks++; if (stat_ins !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL invalid_status got ins=%b h=%b exp 1 1", stat_ins, halted); end
    checks++; if (out_valid !== 1'b1 || out_icode !== 4'hC || out_dstE !== NONE || out_dstM !== NONE)
      begin errors++; $display("FAIL invalid_pass got v=%b icode=%h dstE=%h dstM=%h exp v=1 icode=c dstE=f dstM=f",
                               out_valid, out_icode, out_dstE, out_dstM); end
  endtask

  initial begin
    rst_n = 0;
    in_icode = 0; in_ifun = 0; in_rA = 0; in_rB = 0; in_valC = 0;
    wb_icode = 0; wb_cnd = 0; wb_dstE = NONE; wb_dstM = NONE; wb_valE = 0; wb_valM = 0;
    idle();
    model_reset();
    test_reset();
    test_irmovq();
    test_rrmovq();
    test_cmov();
    test_popq_rsp();
    test_backpressure();
    test_random();
    test_forward();
    test_reset_mid();
    test_halt();
    test_invalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
